// File: rtl/axil_pkg.sv
// Shared AXI4-Lite command-master types: FSM state encoding and response codes.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master with a single outstanding transaction: takes one command,
// runs the AW/W/B or AR/R exchange, and holds the result until it is consumed.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int         AXI_AWIDTH = 12,
    parameter int         AXI_DWIDTH = 32,
    parameter logic [2:0] AXI_PROT   = 3'b000
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AXI_AWIDTH-1:0]   cmd_addr,
    input  logic [AXI_DWIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DWIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [AXI_DWIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic [AXI_AWIDTH-1:0]   awaddr,
    output logic                    awvalid,
    output logic [2:0]              awprot,
    input  logic                    awready,
    output logic [AXI_DWIDTH-1:0]   wdata,
    output logic [AXI_DWIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    output logic                    bready,
    input  logic                    bvalid,
    input  logic [1:0]              bresp,
    output logic [AXI_AWIDTH-1:0]   araddr,
    output logic                    arvalid,
    output logic [2:0]              arprot,
    input  logic                    arready,
    output logic                    rready,
    input  logic [AXI_DWIDTH-1:0]   rdata,
    input  logic                    rvalid,
    input  logic [1:0]              rresp,

    output logic                    busy
);

    localparam int STRB_W = AXI_DWIDTH / 8;

    axil_state_e             state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [AXI_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    busy_q, busy_d;
    logic                    idle_q, idle_d;
    logic                    aw_done, w_done;

    // Gated by rst so the accept window never opens while reset is held.
    assign cmd_ready = idle_q & ~rst;

    // A channel counts as done once its VALID has already dropped or is being accepted now.
    assign aw_done = ~awvalid_q | awready;
    assign w_done  = ~wvalid_q  | wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        busy_d      = busy_q;
        idle_d      = idle_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    busy_d  = 1'b1;
                    idle_d  = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q  & ~wready;
                if (aw_done && w_done) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                end
            end
            ST_RD_REQ: begin
                if (arready) begin
                    state_d   = ST_RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (rvalid) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    idle_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idle_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            busy_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            busy_q      <= busy_d;
            idle_q      <= idle_d;
        end
    end

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = AXI_PROT;
    assign arprot    = AXI_PROT;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign bready    = bready_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: memory-backed stalling AXI4-Lite slave, directed
// vector table, reset-abort sequence and a random run against a reference memory.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bready, bvalid, arvalid, arready, rready, rvalid;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          busy;

    axil_cmd_master #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .AXI_PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awprot(awprot), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bvalid(bvalid), .bresp(bresp),
        .araddr(araddr), .arvalid(arvalid), .arprot(arprot), .arready(arready),
        .rready(rready), .rdata(rdata), .rvalid(rvalid), .rresp(rresp),
        .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- slave model ----------------
    int          aw_d, w_d, ar_d, b_d, r_d;
    logic [1:0]  fixed_resp;
    bit          rand_resp;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit          aw_got, w_got, ar_pend;
    logic [AW-1:0] aw_addr_c, ar_addr_c, last_awaddr, last_araddr;
    logic [DW-1:0] w_data_c;
    logic [SW-1:0] w_strb_c;
    logic [DW-1:0] smem [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;

    assign awready = (aw_wait >= aw_d);
    assign wready  = (w_wait >= w_d);
    assign arready = (ar_wait >= ar_d);

    function automatic logic [1:0] slv_resp(input logic [AW-1:0] a);
        return rand_resp ? a[5:4] : fixed_resp;
    endfunction

    always @(posedge clk) begin : slave
        bit aw_hs, w_hs, ar_hs, aw_have, w_have;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 0; w_got <= 0; ar_pend <= 0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            if (aw_hs) begin aw_wait <= 0; aw_addr_c <= awaddr; last_awaddr <= awaddr; n_aw <= n_aw + 1; end
            else if (awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) begin w_wait <= 0; w_data_c <= wdata; w_strb_c <= wstrb; n_w <= n_w + 1; end
            else if (wvalid) w_wait <= w_wait + 1;
            if (ar_hs) begin ar_wait <= 0; ar_addr_c <= araddr; last_araddr <= araddr; n_ar <= n_ar + 1; end
            else if (arvalid) ar_wait <= ar_wait + 1;

            aw_have = aw_got || aw_hs;
            w_have  = w_got || w_hs;
            wa = aw_hs ? awaddr : aw_addr_c;
            wd = w_hs ? wdata : w_data_c;
            ws = w_hs ? wstrb : w_strb_c;
            if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
            if (!bvalid && aw_have && w_have) begin
                if (b_wait >= b_d) begin
                    bvalid <= 1'b1; bresp <= slv_resp(wa); b_wait <= 0; aw_got <= 0; w_got <= 0;
                    for (int i = 0; i < SW; i++)
                        if (ws[i]) smem[wa[11:2]][8*i +: 8] <= wd[8*i +: 8];
                end else begin
                    b_wait <= b_wait + 1; aw_got <= 1; w_got <= 1;
                end
            end else begin
                aw_got <= aw_have; w_got <= w_have;
            end

            ra = ar_hs ? araddr : ar_addr_c;
            if (rvalid && rready) begin rvalid <= 1'b0; n_r <= n_r + 1; end
            if (!rvalid && (ar_pend || ar_hs)) begin
                if (r_wait >= r_d) begin
                    rvalid <= 1'b1; rdata <= smem[ra[11:2]]; rresp <= slv_resp(ra); r_wait <= 0; ar_pend <= 0;
                end else begin
                    r_wait <= r_wait + 1; ar_pend <= 1;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AW-1:0] p_awa, p_ara;
    logic [DW-1:0] p_wd;
    logic [SW-1:0] p_ws;

    always @(negedge clk) begin
        if (rst) begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end else begin
            if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awa});
            if (p_awv && p_awr)  chk("aw_drop", awvalid, 1'b0);
            if (p_wv && !p_wr)   chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, p_wd, p_ws});
            if (p_wv && p_wr)    chk("w_drop", wvalid, 1'b0);
            if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_ara});
            if (p_arv && p_arr)  chk("ar_drop", arvalid, 1'b0);
            if (cmd_ready || rsp_valid) chk("quiet", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
            chk("busy", busy, !cmd_ready);
            p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
            p_wv  <= wvalid;  p_wr  <= wready;  p_wd  <= wdata; p_ws <= wstrb;
            p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
        end
    end

    // ---------------- command driver ----------------
    typedef struct packed {
        logic          wr;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } rsp_t;

    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] ws, input int hold, output rsp_t r, output int lat);
        int guard;
        bit acc, seen, stable;
        r = '0; lat = -1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        guard = 0; acc = 0;
        while (!acc && guard < 100) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1; guard++;
        end
        // scramble the command bus so any late sampling of it shows up
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
        if (!acc) begin chk("accept_timeout", 0, 1); return; end
        lat = 0; seen = 0;
        while (!seen && lat < 200) begin
            @(negedge clk); lat++; seen = rsp_valid;
            if (!seen) begin @(posedge clk); #1; end
        end
        if (!seen) begin chk("rsp_timeout", 0, 1); return; end
        r = {rsp_write, rsp_resp, rsp_rdata};
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || ({rsp_write, rsp_resp, rsp_rdata} != r)) stable = 0;
        end
        if (hold > 0) chk("rsp_hold", stable, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        for (int i = 0; i < SW; i++)
            if (s[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            awd, wd, ard, bd, rd;
        logic [1:0]    resp;
        int            hold;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
        int            exp_lat;
    } vec_t;

    vec_t vt [12];

    initial begin
        rsp_t r;
        int lat, a0, w0, b0, ar0, r0, mism;
        bit wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        logic [46:0] exp;

        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
        aw_d = 0; w_d = 0; ar_d = 0; b_d = 0; r_d = 0; fixed_resp = RESP_OKAY; rand_resp = 0;
        for (int i = 0; i < 1024; i++) begin
            smem[i]    = {16'(i), ~16'(i)};
            ref_mem[i] = {16'(i), ~16'(i)};
        end
        smem[4]  = 32'h12345678; ref_mem[4]  = 32'h12345678;
        smem[12] = 32'h5A5A0030; ref_mem[12] = 32'h5A5A0030;

        //          wr addr     wdata         strb  aw w ar b r  resp         hold exp_rdata     exp_resp     lat
        vt[0]  = '{1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY,   0,  32'h0,        RESP_OKAY,   3};
        vt[1]  = '{0, 12'h004, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   0,  32'hDEADBEEF, RESP_OKAY,   3};
        vt[2]  = '{1, 12'h004, 32'h11223344, 4'h3, 0, 0, 0, 0, 0, RESP_OKAY,   1,  32'h0,        RESP_OKAY,   3};
        vt[3]  = '{0, 12'h004, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   0,  32'hDEAD3344, RESP_OKAY,   3};
        vt[4]  = '{0, 12'h010, 32'h0,        4'h0, 0, 0, 2, 0, 5, RESP_OKAY,   0,  32'h12345678, RESP_OKAY,  10};
        vt[5]  = '{1, 12'h020, 32'hCAFEF00D, 4'hF, 4, 0, 0, 0, 0, RESP_OKAY,   0,  32'h0,        RESP_OKAY,   7};
        vt[6]  = '{1, 12'h024, 32'h0BADC0DE, 4'hF, 0, 4, 0, 0, 0, RESP_OKAY,   0,  32'h0,        RESP_OKAY,   7};
        vt[7]  = '{0, 12'h030, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_SLVERR, 10, 32'h5A5A0030, RESP_SLVERR, 3};
        vt[8]  = '{1, 12'h040, 32'h01020304, 4'hC, 0, 0, 0, 2, 0, RESP_DECERR, 0,  32'h0,        RESP_DECERR, 5};
        vt[9]  = '{0, 12'h020, 32'h0,        4'h0, 0, 0, 1, 0, 1, RESP_OKAY,   2,  32'hCAFEF00D, RESP_OKAY,   5};
        vt[10] = '{0, 12'h024, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_EXOKAY, 0,  32'h0BADC0DE, RESP_EXOKAY, 3};
        vt[11] = '{0, 12'h040, 32'h0,        4'h0, 0, 0, 0, 0, 0, RESP_OKAY,   0,  32'h0102FFEF, RESP_OKAY,   3};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}, 7'b0);
        chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, '0);
        chk("rst_axi_payload", {awaddr, araddr, wdata, wstrb}, '0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_release", {cmd_ready, busy, awprot, arprot}, {1'b1, 1'b0, 6'b0});
        @(posedge clk); #1;

        // directed vector table
        foreach (vt[i]) begin
            aw_d = vt[i].awd; w_d = vt[i].wd; ar_d = vt[i].ard; b_d = vt[i].bd; r_d = vt[i].rd;
            fixed_resp = vt[i].resp;
            a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
            if (vt[i].wr) ref_write(vt[i].addr, vt[i].wdata, vt[i].wstrb);
            do_cmd(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].hold, r, lat);
            chk($sformatf("vec%0d_rsp", i), r, {vt[i].wr, vt[i].exp_resp, vt[i].exp_rdata});
            chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_beats", i),
                {8'(n_aw - a0), 8'(n_w - w0), 8'(n_b - b0), 8'(n_ar - ar0), 8'(n_r - r0)},
                vt[i].wr ? 40'h0101010000 : 40'h0000000101);
            chk($sformatf("vec%0d_addr", i), vt[i].wr ? last_awaddr : last_araddr, vt[i].addr);
        end

        // reset while a write is stalled in the request phase
        aw_d = 20; w_d = 20; b_d = 0; fixed_resp = RESP_OKAY;
        a0 = n_aw; w0 = n_w; b0 = n_b;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h080; cmd_wdata = 32'hFEEDFACE; cmd_wstrb = 4'hF;
        @(negedge clk); chk("abort_accept", cmd_ready, 1'b1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); chk("abort_pending", {awvalid, wvalid, busy}, 3'b111);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("abort_rst_ready", cmd_ready, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_cleared", {awvalid, wvalid, arvalid, rsp_valid, busy, cmd_ready}, 6'b000001);
        chk("abort_no_beats", {8'(n_aw - a0), 8'(n_w - w0), 8'(n_b - b0)}, 24'h0);
        @(posedge clk); #1;
        aw_d = 0; w_d = 0;
        do_cmd(1'b0, 12'h080, '0, '0, 0, r, lat);
        chk("abort_read", r, {1'b0, RESP_OKAY, ref_mem[12'h080 >> 2]});
        chk("abort_read_lat", lat, 3);

        // random back-to-back traffic against the reference memory
        rand_resp = 1;
        for (int k = 0; k < 1000; k++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 63) << 2);
            wd   = $urandom;
            ws   = SW'($urandom);
            aw_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            w_d  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            ar_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            b_d  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            r_d  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            if (wr) begin
                exp = {1'b1, addr[5:4], 32'h0, addr};
                ref_write(addr, wd, ws);
            end else begin
                exp = {1'b0, addr[5:4], ref_mem[addr[11:2]], addr};
            end
            do_cmd(wr, addr, wd, ws, int'($urandom_range(0, 2)), r, lat);
            chk("rand_rsp", {r, wr ? last_awaddr : last_araddr}, exp);
        end
        chk("rand_beats", {n_aw - n_w, n_aw - n_b, n_ar - n_r}, 96'h0);

        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (smem[i] !== ref_mem[i]) mism++;
        chk("mem_final", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
